// File: rtl/slave_port_pkg.sv
// Shared definitions for the serial slave port: default geometry and the
// transfer-sequencing state encoding.
package slave_port_pkg;

    localparam int DEF_ADDR_WIDTH  = 12;
    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_BURST_WIDTH = 4;
    localparam int DEF_MEM_DEPTH   = 4096;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WDATA = 3'd2,
        WMEM  = 3'd3,
        RMEM  = 3'd4,
        RDATA = 3'd5
    } state_t;

endpackage

// File: rtl/slave_port_bram.sv
// slave_bram: single-port word storage for the slave port.
//   clk_i    rising-edge clock
//   we_i     write strobe, word written at addr_i on the clock edge
//   re_i     read strobe, rdata_o updated one edge later and held otherwise
//   addr_i   word index
//   wdata_i  write word
//   rdata_o  registered read word
// No reset: contents survive a port reset.
module slave_bram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4096
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0]    wdata_i,
    output logic [DATA_WIDTH-1:0]    rdata_o
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem[addr_i];
        end
    end

endmodule

// File: rtl/slave_port.sv
// slave_port: bit-serial slave with burst read/write access to local storage.
//   clk, rst (async, active-low)
//   master_valid   master presents a bit this cycle
//   master_ready   master accepts the current read bit
//   rx_address / rx_burst_num / rx_data   serial inputs, LSB first
//   write_en / read_en   transfer type, sampled on the first header bit
//   tx_data / slave_valid   serial read data, LSB first
//   slave_ready    slave accepting bits
//   addr_err       sticky out-of-range start address
// Build option: SLAVE_ADDR_CHECK_EN enables start-address range checking;
// without it addresses wrap to the low log2(MEM_DEPTH) bits and addr_err is 0.
//
// state | meaning
// IDLE  | waiting for first header bit
// ADDR  | shifting address (and burst count) bits
// WDATA | shifting a write word
// WMEM  | committing the write word, advancing address
// RMEM  | issuing the memory read for the next beat
// RDATA | shifting the read word out
module slave_port
    import slave_port_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int BURST_WIDTH = DEF_BURST_WIDTH,
    parameter int MEM_DEPTH   = DEF_MEM_DEPTH
) (
    input  logic clk,
    input  logic rst,
    input  logic master_valid,
    input  logic master_ready,
    input  logic rx_address,
    input  logic rx_data,
    input  logic rx_burst_num,
    input  logic write_en,
    input  logic read_en,
    output logic tx_data,
    output logic slave_valid,
    output logic slave_ready,
    output logic addr_err
);

    localparam int IDXW = $clog2(MEM_DEPTH);
    localparam int ACW  = $clog2(ADDR_WIDTH);
    localparam int DCW  = $clog2(DATA_WIDTH);

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  addr_sr_q, addr_sr_d;
    logic [ACW-1:0]         addr_cnt_q, addr_cnt_d;
    logic [BURST_WIDTH-1:0] burst_sr_q, burst_sr_d;
    logic [BURST_WIDTH-1:0] beats_q, beats_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [DCW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [IDXW-1:0]        mem_addr_q, mem_addr_d;
    logic                   wr_q, wr_d;
    logic                   rd_q, rd_d;

    logic [ADDR_WIDTH-1:0]  addr_shift;
    logic [BURST_WIDTH-1:0] burst_shift;
    logic                   addr_done;
    logic                   mem_we, mem_re;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic                   bad_q;
    logic                   unused_bits;

`ifdef SLAVE_ADDR_CHECK_EN
    // bad_q marks the current transfer as out of range; addr_err remembers it.
    logic err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bad_q <= 1'b0;
            err_q <= 1'b0;
        end else if (addr_done) begin
            bad_q <= (32'(addr_shift) >= MEM_DEPTH);
            if ((32'(addr_shift) >= MEM_DEPTH) && (wr_q || rd_q)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign addr_err = err_q;
`else
    assign bad_q    = 1'b0;
    assign addr_err = 1'b0;
`endif

    // Upper address bits only matter to the range check.
    assign unused_bits = ^{addr_shift, addr_done};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_sr_q  <= '0;
            addr_cnt_q <= '0;
            burst_sr_q <= '0;
            beats_q    <= '0;
            wdata_q    <= '0;
            bit_cnt_q  <= '0;
            mem_addr_q <= '0;
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_sr_q  <= addr_sr_d;
            addr_cnt_q <= addr_cnt_d;
            burst_sr_q <= burst_sr_d;
            beats_q    <= beats_d;
            wdata_q    <= wdata_d;
            bit_cnt_q  <= bit_cnt_d;
            mem_addr_q <= mem_addr_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_sr_d   = addr_sr_q;
        addr_cnt_d  = addr_cnt_q;
        burst_sr_d  = burst_sr_q;
        beats_d     = beats_q;
        wdata_d     = wdata_q;
        bit_cnt_d   = bit_cnt_q;
        mem_addr_d  = mem_addr_q;
        wr_d        = wr_q;
        rd_d        = rd_q;
        addr_done   = 1'b0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        // LSB-first: new bits enter at the top and move down.
        addr_shift  = {rx_address, addr_sr_q[ADDR_WIDTH-1:1]};
        burst_shift = {rx_burst_num, burst_sr_q[BURST_WIDTH-1:1]};

        unique case (state_q)
            IDLE: begin
                if (master_valid) begin
                    wr_d       = write_en;
                    rd_d       = read_en;
                    addr_sr_d  = addr_shift;
                    burst_sr_d = burst_shift;
                    addr_cnt_d = ACW'(1);
                    state_d    = ADDR;
                end
            end
            ADDR: begin
                if (master_valid) begin
                    addr_sr_d = addr_shift;
                    // Burst bits ride alongside the first BURST_WIDTH address bits.
                    if (32'(addr_cnt_q) < BURST_WIDTH) begin
                        burst_sr_d = burst_shift;
                    end
                    if (addr_cnt_q == ACW'(ADDR_WIDTH - 1)) begin
                        addr_done  = 1'b1;
                        addr_cnt_d = '0;
                        bit_cnt_d  = '0;
                        mem_addr_d = addr_shift[IDXW-1:0];
                        beats_d    = (32'(addr_cnt_q) < BURST_WIDTH) ? burst_shift : burst_sr_q;
                        if (wr_q) begin
                            state_d = WDATA;
                        end else if (rd_q) begin
                            state_d = RMEM;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        addr_cnt_d = addr_cnt_q + ACW'(1);
                    end
                end
            end
            WDATA: begin
                if (master_valid) begin
                    wdata_d = {rx_data, wdata_q[DATA_WIDTH-1:1]};
                    if (bit_cnt_q == DCW'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = WMEM;
                    end else begin
                        bit_cnt_d = bit_cnt_q + DCW'(1);
                    end
                end
            end
            WMEM: begin
                mem_we     = !bad_q;
                mem_addr_d = mem_addr_q + IDXW'(1);
                if (beats_q != '0) begin
                    beats_d = beats_q - BURST_WIDTH'(1);
                    state_d = WDATA;
                end else begin
                    state_d = IDLE;
                end
            end
            RMEM: begin
                mem_re    = 1'b1;
                bit_cnt_d = '0;
                state_d   = RDATA;
            end
            RDATA: begin
                if (master_ready) begin
                    if (bit_cnt_q == DCW'(DATA_WIDTH - 1)) begin
                        bit_cnt_d  = '0;
                        mem_addr_d = mem_addr_q + IDXW'(1);
                        if (beats_q != '0) begin
                            beats_d = beats_q - BURST_WIDTH'(1);
                            state_d = RMEM;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + DCW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign slave_ready = (state_q == IDLE) || (state_q == ADDR) || (state_q == WDATA);
    assign slave_valid = (state_q == RDATA);
    // The read word stays parked in the storage output register for the
    // whole beat, so the current bit is selected from it directly.
    assign tx_data     = (slave_valid && !bad_q) ? rd_data[bit_cnt_q] : 1'b0;

    slave_bram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEM_DEPTH)
    ) u_bram (
        .clk_i   (clk),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .addr_i  (mem_addr_q),
        .wdata_i (wdata_q),
        .rdata_o (rd_data)
    );

endmodule

// File: tb/tb_slave_port.sv
module tb_slave_port;
    import slave_port_pkg::*;

`ifdef SLAVE_ADDR_CHECK_EN
    localparam int TB_DEPTH = 256;
`else
    localparam int TB_DEPTH = 4096;
`endif
    localparam int TB_IW = $clog2(TB_DEPTH);

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic master_valid = 1'b0;
    logic master_ready = 1'b1;
    logic rx_address   = 1'b0;
    logic rx_data      = 1'b0;
    logic rx_burst_num = 1'b0;
    logic write_en     = 1'b0;
    logic read_en      = 1'b0;
    logic tx_data, slave_valid, slave_ready, addr_err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    slave_port #(
        .ADDR_WIDTH  (12),
        .DATA_WIDTH  (8),
        .BURST_WIDTH (4),
        .MEM_DEPTH   (TB_DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .master_valid (master_valid),
        .master_ready (master_ready),
        .rx_address   (rx_address),
        .rx_data      (rx_data),
        .rx_burst_num (rx_burst_num),
        .write_en     (write_en),
        .read_en      (read_en),
        .tx_data      (tx_data),
        .slave_valid  (slave_valid),
        .slave_ready  (slave_ready),
        .addr_err     (addr_err)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] peek(input int a);
        logic [TB_IW-1:0] ix;
        ix = TB_IW'(a);
        return dut.u_bram.mem[ix];
    endfunction

    // Header: 12 address bits, burst bits on the first 4. Type bits are only
    // meaningful on the first cycle; later cycles drive 0 to prove latching,
    // and burst beyond bit 3 drives 1 to catch over-shifting.
    task automatic send_hdr(input logic wr, input logic rd, input logic [11:0] addr,
                            input logic [3:0] burst, input int stall_at);
        for (int i = 0; i < 12; i++) begin
            if (i == stall_at) begin
                master_valid = 1'b0;
                rx_address   = ~addr[i];
                repeat (3) @(negedge clk);
                chk("addr_stall_ready", 32'(slave_ready), 32'd1);
            end
            master_valid = 1'b1;
            write_en     = (i == 0) ? wr : 1'b0;
            read_en      = (i == 0) ? rd : 1'b0;
            rx_address   = addr[i];
            rx_burst_num = (i < 4) ? burst[i] : 1'b1;
            @(negedge clk);
        end
        master_valid = 1'b0;
        write_en     = 1'b0;
        read_en      = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] d);
        for (int i = 0; i < 8; i++) begin
            int guard;
            guard = 0;
            while (!slave_ready && guard < 10) begin
                master_valid = 1'b0;
                @(negedge clk);
                guard++;
            end
            chk("wr_ready", 32'(slave_ready), 32'd1);
            master_valid = 1'b1;
            rx_data      = d[i];
            @(negedge clk);
        end
        master_valid = 1'b0;
    endtask

    task automatic recv_word(input string tag, input logic [7:0] exp, input int stall_at);
        logic [7:0] got;
        got = '0;
        for (int i = 0; i < 8; i++) begin
            int guard;
            guard = 0;
            while (!slave_valid && guard < 10) begin
                @(negedge clk);
                guard++;
            end
            chk({tag, "_valid"}, 32'(slave_valid), 32'd1);
            if (i == stall_at) begin
                master_ready = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    chk({tag, "_stall_bit"}, 32'(tx_data), 32'(exp[i]));
                    chk({tag, "_stall_valid"}, 32'(slave_valid), 32'd1);
                end
                master_ready = 1'b1;
            end
            got[i] = tx_data;
            @(negedge clk);
        end
        chk(tag, 32'(got), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(slave_ready), 32'd1);
        chk("rst_valid", 32'(slave_valid), 32'd0);
        chk("rst_tx", 32'(tx_data), 32'd0);
        chk("rst_err", 32'(addr_err), 32'd0);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        rst = 1'b1;

        // Single write, header starts on the first edge after reset release.
        send_hdr(1'b1, 1'b0, 12'h005, 4'd0, -1);
        chk("t1_wdata_ready", 32'(slave_ready), 32'd1);
        send_word(8'hA5);
        chk("t1_wmem_ready", 32'(slave_ready), 32'd0);
        @(negedge clk);
        chk("t1_idle", 32'(dut.state_q), 32'(IDLE));
        chk("t1_mem005", 32'(peek(12'h005)), 32'h0A5);

        // Burst write with an address stall.
        send_hdr(1'b1, 1'b0, 12'h010, 4'd2, 5);
        send_word(8'h11);
        send_word(8'h22);
        send_word(8'h33);
        @(negedge clk);
        chk("t2_mem010", 32'(peek(12'h010)), 32'h11);
        chk("t2_mem011", 32'(peek(12'h011)), 32'h22);
        chk("t2_mem012", 32'(peek(12'h012)), 32'h33);
        chk("t2_idle", 32'(dut.state_q), 32'(IDLE));

        // Burst read with a read-side stall.
        send_hdr(1'b0, 1'b1, 12'h010, 4'd2, 7);
        chk("t3_rmem_ready", 32'(slave_ready), 32'd0);
        chk("t3_rmem_tx", 32'(tx_data), 32'd0);
        recv_word("t3_rd0", 8'h11, 3);
        recv_word("t3_rd1", 8'h22, -1);
        recv_word("t3_rd2", 8'h33, -1);
        chk("t3_valid_drop", 32'(slave_valid), 32'd0);
        chk("t3_tx_zero", 32'(tx_data), 32'd0);
        chk("t3_idle", 32'(dut.state_q), 32'(IDLE));

        // Neither type bit: header consumed, no access.
        send_hdr(1'b0, 1'b0, 12'h005, 4'd0, -1);
        chk("t4_idle", 32'(dut.state_q), 32'(IDLE));
        chk("t4_mem005", 32'(peek(12'h005)), 32'h0A5);

        // Both type bits: treated as a write.
        send_hdr(1'b1, 1'b1, 12'h020, 4'd0, -1);
        chk("t5_wdata", 32'(dut.state_q), 32'(WDATA));
        send_word(8'h3C);
        @(negedge clk);
        chk("t5_mem020", 32'(peek(12'h020)), 32'h3C);

`ifdef SLAVE_ADDR_CHECK_EN
        // Out-of-range start address.
        send_hdr(1'b1, 1'b0, 12'h000, 4'd0, -1);
        send_word(8'h44);
        @(negedge clk);
        chk("t6_mem000", 32'(peek(0)), 32'h44);
        chk("t6_err_clear", 32'(addr_err), 32'd0);
        send_hdr(1'b1, 1'b0, 12'h100, 4'd0, -1);
        send_word(8'hEE);
        @(negedge clk);
        chk("t6_err_set", 32'(addr_err), 32'd1);
        chk("t6_mem000_kept", 32'(peek(0)), 32'h44);
        send_hdr(1'b0, 1'b1, 12'h100, 4'd0, -1);
        recv_word("t6_oob_read", 8'h00, -1);
        send_hdr(1'b0, 1'b1, 12'h000, 4'd0, -1);
        recv_word("t6_ok_read", 8'h44, -1);
        chk("t6_err_sticky", 32'(addr_err), 32'd1);
`else
        // Address wrap at the top of storage.
        send_hdr(1'b1, 1'b0, 12'hFFF, 4'd1, -1);
        send_word(8'h5A);
        send_word(8'hC3);
        @(negedge clk);
        chk("t6_memFFF", 32'(peek(12'hFFF)), 32'h5A);
        chk("t6_mem000", 32'(peek(0)), 32'hC3);
        send_hdr(1'b0, 1'b1, 12'hFFF, 4'd1, -1);
        recv_word("t6_rdFFF", 8'h5A, -1);
        recv_word("t6_rd000", 8'hC3, -1);
        chk("t6_err_zero", 32'(addr_err), 32'd0);
`endif

        // Reset in the middle of a write word.
        send_hdr(1'b1, 1'b0, 12'h030, 4'd0, -1);
        send_word(8'h77);
        @(negedge clk);
        send_hdr(1'b1, 1'b0, 12'h030, 4'd0, -1);
        for (int i = 0; i < 4; i++) begin
            master_valid = 1'b1;
            rx_data      = 1'b0;
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        chk("t7_rst_ready", 32'(slave_ready), 32'd1);
        chk("t7_rst_state", 32'(dut.state_q), 32'(IDLE));
        chk("t7_rst_err", 32'(addr_err), 32'd0);
        master_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t7_mem030", 32'(peek(12'h030)), 32'h77);
        send_hdr(1'b0, 1'b1, 12'h030, 4'd0, -1);
        recv_word("t7_rd030", 8'h77, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/slave_port.md
SLAVE_PORT -- requirements
Module: slave_port

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, 12, serial address length in bits.
REQ-002 SHALL have parameter DATA_WIDTH, 8, serial data word length in bits.
REQ-003 SHALL have parameter BURST_WIDTH, 4, serial burst-count length in bits (≤ ADDR_WIDTH).
REQ-004 SHALL have parameter MEM_DEPTH, 4096, words of local storage (power of two, ≤ 2^ADDR_WIDTH).
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk in 1 (all logic on rising edge); rst in 1 (async, active-low).
REQ-006 SHALL have ports: master_valid in 1 (master driving a bit); master_ready in 1 (master accepts read bit).
REQ-007 SHALL have ports: rx_address in 1 (serial address, LSB first); rx_data in 1 (serial write data, LSB first); rx_burst_num in 1 (serial burst count, LSB first).
REQ-008 SHALL have ports: write_en in 1 and read_en in 1 (transfer type); tx_data out 1 (serial read data, LSB first).
REQ-009 SHALL have ports: slave_valid out 1 (tx_data bit valid); slave_ready out 1 (slave accepting bits); addr_err out 1 (sticky address error).

Function
REQ-010 SHALL implement states IDLE, ADDR, WDATA, WMEM, RMEM, RDATA.
REQ-011 IDLE: slave_ready=1; first cycle with master_valid=1 latches write_en/read_en, shifts bit 0 of rx_address (and rx_burst_num), goes to ADDR.
REQ-012 ADDR: each master_valid=1 cycle shifts one address bit, plus one burst bit while fewer than BURST_WIDTH taken; master_valid=0 stalls, no shift.
REQ-013 After ADDR_WIDTH address bits: write_en=1 -> WDATA; else read_en=1 -> RMEM; neither -> IDLE, no access.
REQ-014 write_en and read_en both 1 on first cycle SHALL be treated as a write.
REQ-015 Beat count SHALL equal burst_num+1 (1..2^BURST_WIDTH).
REQ-016 WDATA: slave_ready=1; shifts rx_data on master_valid=1 cycles; after DATA_WIDTH bits -> WMEM.
REQ-017 WMEM: one cycle, slave_ready=0, word written at current address; address+1 modulo MEM_DEPTH; -> WDATA if beats remain, else IDLE.
REQ-018 RMEM: one cycle, slave_ready=0, memory read issued (1-cycle latency) into shift register; -> RDATA.
REQ-019 RDATA: slave_valid=1, tx_data=current bit; bit advances only on cycles with master_ready=1; master_ready=0 holds bit and slave_valid.
REQ-020 After last bit of a read beat accepted: address+1 modulo MEM_DEPTH; -> RMEM if beats remain, else IDLE with slave_valid=0 next cycle.
REQ-021 slave_ready SHALL be 0 in ADDR-to-RMEM transition, RMEM, RDATA, WMEM; 1 in IDLE, ADDR, WDATA.
REQ-022 Address above MEM_DEPTH-1 SHALL use low log2(MEM_DEPTH) bits (wrap) unless REQ-029 applies.
REQ-023 tx_data SHALL be 0 whenever slave_valid=0.

Reset
REQ-024 rst=0 SHALL asynchronously force IDLE, slave_ready=1, slave_valid=0, tx_data=0, addr_err=0, counters/shift registers 0.
REQ-025 Reset mid-transfer SHALL abandon it; partially received beat not written; memory contents not cleared.
REQ-026 First transfer SHALL be accepted on first rising edge after rst deasserts.

Configuration
REQ-027 Macro SLAVE_ADDR_CHECK_EN SHALL control address range checking.
REQ-028 Undefined: addr_err tied 0; REQ-022 wrap applies.
REQ-029 Defined: start address ≥ MEM_DEPTH sets addr_err=1 (sticky until reset); full handshake still runs, writes discarded, read bits driven 0.

Structure
REQ-030 Shared package slave_port_pkg SHALL hold the state enumeration and default parameter constants.
REQ-031 Storage SHALL be sub-module slave_bram (single-port, synchronous write, 1-cycle registered read, no reset).

Verification
REQ-032 Single write: addr 0x005, burst 0, data 0xA5 -> mem[5]=0xA5, back to IDLE 1 cycle after WMEM.
REQ-033 Burst read: preload mem[0x010..0x012]=0x11,0x22,0x33, burst 2, master_ready=1 -> 24 tx bits LSB first = 0x11,0x22,0x33; slave_valid drops after.
REQ-034 Stalls: master_valid low 3 cycles mid-address, master_ready low 2 cycles mid-read -> no lost/duplicated bits; data unchanged.
REQ-035 Wrap: write burst 1 at addr 0xFFF, MEM_DEPTH 4096 -> words at 0xFFF and 0x000.
REQ-036 Reset mid-WDATA after 4 bits -> IDLE, slave_ready=1, target word unchanged.
REQ-037 With SLAVE_ADDR_CHECK_EN, MEM_DEPTH 256, write addr 0x100 -> addr_err=1, memory unchanged; read returns 0x00.
